// File: rtl/async_fifo_asym_v2_if.sv
// Handshake/bus bundle for async_fifo_asym_v2.
//   master : the user side; drives wr_en/wr_data/rd_en and observes flags, counts and read data.
//   slave  : the FIFO side; samples requests and drives data, flags, counts and pulses.
//   WCW/RCW: count widths in write/read words (ADDR_W+1-WR_L2 / ADDR_W+1-RD_L2).
`timescale 1ns/1ps
interface async_fifo_asym_v2_if #(
  parameter int unsigned WR_WIDTH = 32,
  parameter int unsigned RD_WIDTH = 8,
  parameter int unsigned WCW      = 3,
  parameter int unsigned RCW      = 5
);
  logic                wr_en;
  logic [WR_WIDTH-1:0] wr_data;
  logic                fifo_full;
  logic                prog_full;
  logic                wr_overflow;
  logic [WCW-1:0]      wr_data_count;
  logic                rd_en;
  logic [RD_WIDTH-1:0] rd_data;
  logic                rd_valid;
  logic                fifo_empty;
  logic                prog_empty;
  logic                rd_underflow;
  logic [RCW-1:0]      rd_data_count;

  modport master (
    output wr_en, wr_data, rd_en,
    input  fifo_full, prog_full, wr_overflow, wr_data_count,
    input  rd_data, rd_valid, fifo_empty, prog_empty, rd_underflow, rd_data_count
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output fifo_full, prog_full, wr_overflow, wr_data_count,
    output rd_data, rd_valid, fifo_empty, prog_empty, rd_underflow, rd_data_count
  );
endinterface

// File: rtl/async_fifo_asym_v2.sv
// Dual-clock FIFO with power-of-two width conversion in either direction.
// Storage is DEPTH units of UNIT_W; pointers count units with an extra wrap bit.
// Only the word-granular part of each pointer is Gray-coded and synchronised.
// Ports:
//   wr_clk / wr_rst_n : write clock, async active-low write-domain reset
//   rd_clk / rd_rst_n : read clock, async active-low read-domain reset
//   bus (slave)       : wr_en, wr_data, fifo_full, prog_full, wr_overflow, wr_data_count,
//                       rd_en, rd_data, rd_valid, fifo_empty, prog_empty, rd_underflow,
//                       rd_data_count
`timescale 1ns/1ps
module async_fifo_asym_v2 #(
  parameter int unsigned WR_WIDTH = 32,
  parameter int unsigned RD_WIDTH = 8,
  parameter int unsigned UNIT_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned WR_R     = 4,
  parameter int unsigned RD_R     = 1,
  parameter int unsigned WR_L2    = 2,
  parameter int unsigned RD_L2    = 0,
  parameter int unsigned FWFT     = 1,
  parameter int unsigned SYNC_STG = 2,
  parameter int unsigned PFULL    = 3,
  parameter int unsigned PEMPTY   = 1
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 wr_clk,
  input  logic                 wr_rst_n,
  async_fifo_asym_v2_if.slave  bus
);
  localparam int unsigned PW  = ADDR_W + 1;
  localparam int unsigned WCW = ADDR_W + 1 - WR_L2;
  localparam int unsigned RCW = ADDR_W + 1 - RD_L2;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [UNIT_W-1:0] mem_q [DEPTH];

  // ---------------- write domain ----------------
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_sync, wr_diff;
  logic [WCW-1:0] wr_gray_q, wr_cnt_c;
  logic [RCW-1:0] rd_gray_sync_q [SYNC_STG];
  logic           wr_full_c, wr_acc_c, wr_overflow_q;

  // Read pointer back in units; low RD_L2 bits are always zero on that side.
  assign rd_ptr_sync = gray2bin(PW'(rd_gray_sync_q[SYNC_STG-1])) << RD_L2;
  assign wr_diff     = wr_ptr_q - rd_ptr_sync;
  assign wr_full_c   = wr_diff > PW'(DEPTH - WR_R);
  assign wr_acc_c    = bus.wr_en && !wr_full_c;
  assign wr_ptr_d    = wr_acc_c ? wr_ptr_q + PW'(WR_R) : wr_ptr_q;
  assign wr_cnt_c    = WCW'(wr_diff >> WR_L2);

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_q      <= '0;
      wr_gray_q     <= '0;
      wr_overflow_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STG; i++) rd_gray_sync_q[i] <= '0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      wr_gray_q         <= WCW'(bin2gray(wr_ptr_d >> WR_L2));
      wr_overflow_q     <= bus.wr_en && wr_full_c;
      rd_gray_sync_q[0] <= rd_gray_q;
      for (int unsigned i = 1; i < SYNC_STG; i++) rd_gray_sync_q[i] <= rd_gray_sync_q[i-1];
    end
  end

  // Lowest slice goes to the lowest unit address.
  always_ff @(posedge wr_clk) begin
    if (wr_acc_c) begin
      for (int unsigned k = 0; k < WR_R; k++)
        mem_q[ADDR_W'(wr_ptr_q) + ADDR_W'(k)] <= bus.wr_data[k*UNIT_W +: UNIT_W];
    end
  end

  assign bus.fifo_full     = wr_full_c;
  assign bus.prog_full     = wr_cnt_c >= WCW'(PFULL);
  assign bus.wr_overflow   = wr_overflow_q;
  assign bus.wr_data_count = wr_cnt_c;

  // ---------------- read domain ----------------
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_sync, rd_diff, raddr_c;
  logic [RCW-1:0]      rd_gray_q, rd_cnt_c;
  logic [WCW-1:0]      wr_gray_sync_q [SYNC_STG];
  logic [RD_WIDTH-1:0] ram_word_c, rd_data_q;
  logic                rd_empty_c, rd_acc_c, rd_valid_q, rd_underflow_q;

  assign wr_ptr_sync = gray2bin(PW'(wr_gray_sync_q[SYNC_STG-1])) << WR_L2;
  assign rd_diff     = wr_ptr_sync - rd_ptr_q;
  assign rd_empty_c  = rd_diff < PW'(RD_R);
  assign rd_acc_c    = bus.rd_en && !rd_empty_c;
  assign rd_ptr_d    = rd_acc_c ? rd_ptr_q + PW'(RD_R) : rd_ptr_q;
  assign rd_cnt_c    = RCW'(rd_diff >> RD_L2);

  // In FWFT mode look one word ahead while popping so the next head is ready.
  always_comb begin
    raddr_c    = rd_ptr_q;
    ram_word_c = '0;
    if (FWFT != 0 && rd_acc_c) raddr_c = rd_ptr_q + PW'(RD_R);
    for (int unsigned k = 0; k < RD_R; k++)
      ram_word_c[k*UNIT_W +: UNIT_W] = mem_q[ADDR_W'(raddr_c) + ADDR_W'(k)];
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q       <= '0;
      rd_gray_q      <= '0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_underflow_q <= 1'b0;
      for (int unsigned i = 0; i < SYNC_STG; i++) wr_gray_sync_q[i] <= '0;
    end else begin
      rd_ptr_q          <= rd_ptr_d;
      rd_gray_q         <= RCW'(bin2gray(rd_ptr_d >> RD_L2));
      rd_underflow_q    <= bus.rd_en && rd_empty_c;
      wr_gray_sync_q[0] <= wr_gray_q;
      for (int unsigned i = 1; i < SYNC_STG; i++) wr_gray_sync_q[i] <= wr_gray_sync_q[i-1];
      if (FWFT != 0) begin
        rd_data_q  <= ram_word_c;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc_c;
        if (rd_acc_c) rd_data_q <= ram_word_c;
      end
    end
  end

  // FWFT data is masked while empty so the head register never shows stale contents.
  assign bus.rd_valid      = (FWFT != 0) ? !rd_empty_c : rd_valid_q;
  assign bus.rd_data       = (FWFT != 0 && rd_empty_c) ? '0 : rd_data_q;
  assign bus.fifo_empty    = rd_empty_c;
  assign bus.prog_empty    = rd_cnt_c <= RCW'(PEMPTY);
  assign bus.rd_underflow  = rd_underflow_q;
  assign bus.rd_data_count = rd_cnt_c;
endmodule

// File: tb/tb_async_fifo_asym_v2.sv
// Bench for async_fifo_asym_v2: a 32->8 FWFT instance and an 8->32 standard-mode instance,
// sharing 100 MHz write and ~37 MHz read clocks. Read data is checked by per-instance
// scoreboard queues popped by monitors on the read clock's falling edge.
`timescale 1ns/1ps
module tb_async_fifo_asym_v2;
  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rst_n, rd_rst_n;

  always #5 wr_clk = ~wr_clk;
  initial begin
    #3;
    forever #13.5 rd_clk = ~rd_clk;
  end

  async_fifo_asym_v2_if #(.WR_WIDTH(32), .RD_WIDTH(8), .WCW(3), .RCW(5)) ba ();
  async_fifo_asym_v2_if #(.WR_WIDTH(8), .RD_WIDTH(32), .WCW(5), .RCW(3)) bb ();

  async_fifo_asym_v2 #(
    .WR_WIDTH(32), .RD_WIDTH(8), .UNIT_W(8), .DEPTH(16), .ADDR_W(4), .WR_R(4), .RD_R(1),
    .WR_L2(2), .RD_L2(0), .FWFT(1), .SYNC_STG(2), .PFULL(3), .PEMPTY(1)
  ) u_a (.rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .bus(ba));

  async_fifo_asym_v2 #(
    .WR_WIDTH(8), .RD_WIDTH(32), .UNIT_W(8), .DEPTH(16), .ADDR_W(4), .WR_R(1), .RD_R(4),
    .WR_L2(0), .RD_L2(2), .FWFT(0), .SYNC_STG(2), .PFULL(3), .PEMPTY(1)
  ) u_b (.rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .bus(bb));

  int n_pass  = 0;
  int n_total = 0;
  int viol    = 0;
  int n_acc   = 0;
  bit writer_done;
  logic [7:0]  qa [$];
  logic [31:0] qb [$];
  logic [7:0]  bv [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitors: an FWFT pop consumes the word shown before the edge; standard mode checks on rd_valid.
  always @(negedge rd_clk) begin
    if (ba.rd_en && ba.rd_valid) begin
      if (qa.size() == 0) begin
        n_total++;
        $display("FAIL a_rd: unexpected data %0h with empty scoreboard", ba.rd_data);
      end else chk("a_rd", ba.rd_data, qa.pop_front());
    end
    if (bb.rd_valid) begin
      if (qb.size() == 0) begin
        n_total++;
        $display("FAIL b_rd: unexpected data %0h with empty scoreboard", bb.rd_data);
      end else chk("b_rd", bb.rd_data, qb.pop_front());
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached after %0d checks", n_total);
    $fatal(1);
  end

  task automatic wr_a(input logic [31:0] d, input bit push);
    ba.wr_en   = 1'b1;
    ba.wr_data = d;
    if (push) for (int k = 0; k < 4; k++) qa.push_back(d[k*8 +: 8]);
    @(posedge wr_clk); #1;
    ba.wr_en = 1'b0;
  endtask

  task automatic pop_a(input int n);
    int got = 0;
    int budget = 0;
    @(posedge rd_clk); #1;
    while (got < n && budget < 200) begin
      budget++;
      if (ba.rd_valid) begin
        ba.rd_en = 1'b1;
        got++;
      end
      @(posedge rd_clk); #1;
      ba.rd_en = 1'b0;
    end
    if (got < n) begin
      n_total++;
      $display("FAIL pop_a_timeout: popped %0d expected %0d", got, n);
    end
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_a_empty"},  ba.fifo_empty, 1);
    chk({tag, "_a_full"},   ba.fifo_full, 0);
    chk({tag, "_a_pempty"}, ba.prog_empty, 1);
    chk({tag, "_a_pfull"},  ba.prog_full, 0);
    chk({tag, "_a_wcnt"},   ba.wr_data_count, 0);
    chk({tag, "_a_rcnt"},   ba.rd_data_count, 0);
    chk({tag, "_a_valid"},  ba.rd_valid, 0);
    chk({tag, "_a_data"},   ba.rd_data, 0);
    chk({tag, "_a_ovf"},    ba.wr_overflow, 0);
    chk({tag, "_a_unf"},    ba.rd_underflow, 0);
  endtask

  initial begin
    ba.wr_en = 1'b0; ba.wr_data = '0; ba.rd_en = 1'b0;
    bb.wr_en = 1'b0; bb.wr_data = '0; bb.rd_en = 1'b0;
    wr_rst_n = 1'b0; rd_rst_n = 1'b0;
    repeat (5) @(posedge rd_clk); #1;
    chk_reset_a("rst");
    chk("rst_b_empty", bb.fifo_empty, 1);
    chk("rst_b_valid", bb.rd_valid, 0);
    chk("rst_b_data",  bb.rd_data, 0);
    chk("rst_b_pempty", bb.prog_empty, 1);
    wr_rst_n = 1'b1; rd_rst_n = 1'b1;

    // 32->8 FWFT ordering
    @(posedge wr_clk); #1;
    wr_a(32'h44332211, 1'b1);
    wr_a(32'h88776655, 1'b1);
    @(posedge rd_clk); #1;
    for (int i = 0; i < 20 && ba.rd_data_count != 5'd8; i++) begin @(posedge rd_clk); #1; end
    chk("t1_rd_count", ba.rd_data_count, 8);
    chk("t1_pempty", ba.prog_empty, 0);
    pop_a(8);
    chk("t1_empty_after_8", ba.fifo_empty, 1);
    chk("t1_valid_after_8", ba.rd_valid, 0);

    // Fill to full across the pointer wrap, then overflow
    repeat (10) @(posedge wr_clk); #1;
    chk("t2_wcnt0", ba.wr_data_count, 0);
    wr_a(32'h13121110, 1'b1);
    wr_a(32'h17161514, 1'b1);
    chk("t2_pfull_after2", ba.prog_full, 0);
    wr_a(32'h1B1A1918, 1'b1);
    chk("t2_pfull_after3", ba.prog_full, 1);
    chk("t2_full_after3", ba.fifo_full, 0);
    chk("t2_wcnt3", ba.wr_data_count, 3);
    wr_a(32'h1F1E1D1C, 1'b1);
    chk("t2_full_after4", ba.fifo_full, 1);
    chk("t2_wcnt4", ba.wr_data_count, 4);
    wr_a(32'hEEEEEEEE, 1'b0);
    chk("t2_ovf_pulse", ba.wr_overflow, 1);
    chk("t2_wcnt_after_ovf", ba.wr_data_count, 4);
    @(posedge wr_clk); #1;
    chk("t2_ovf_drop", ba.wr_overflow, 0);
    pop_a(16);
    chk("t2_empty", ba.fifo_empty, 1);

    // FWFT underflow
    ba.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    ba.rd_en = 1'b0;
    chk("t4_a_unf_pulse", ba.rd_underflow, 1);
    chk("t4_a_rcnt", ba.rd_data_count, 0);
    chk("t4_a_data", ba.rd_data, 0);
    @(posedge rd_clk); #1;
    chk("t4_a_unf_drop", ba.rd_underflow, 0);

    // 8->32 standard mode
    @(posedge wr_clk); #1;
    for (int i = 0; i < 4; i++) begin
      bb.wr_en = 1'b1; bb.wr_data = bv[i];
      @(posedge wr_clk); #1;
      bb.wr_en = 1'b0;
    end
    qb.push_back(32'hD4C3B2A1);
    @(posedge rd_clk); #1;
    for (int i = 0; i < 20 && bb.fifo_empty; i++) begin @(posedge rd_clk); #1; end
    chk("t3_b_nonempty", bb.fifo_empty, 0);
    chk("t3_b_valid_idle", bb.rd_valid, 0);
    bb.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    bb.rd_en = 1'b0;
    chk("t3_b_valid_pulse", bb.rd_valid, 1);
    @(posedge rd_clk); #1;
    chk("t3_b_valid_drop", bb.rd_valid, 0);
    chk("t3_b_empty", bb.fifo_empty, 1);
    bb.rd_en = 1'b1;
    @(posedge rd_clk); #1;
    bb.rd_en = 1'b0;
    chk("t4_b_unf_pulse", bb.rd_underflow, 1);
    chk("t4_b_data_hold", bb.rd_data, 32'hD4C3B2A1);
    chk("t4_b_valid", bb.rd_valid, 0);
    @(posedge rd_clk); #1;
    chk("t4_b_unf_drop", bb.rd_underflow, 0);

    // Random wr_en/rd_en stream, 2500 words in = 10000 bytes out
    writer_done = 1'b0;
    fork
      begin
        int budget = 0;
        @(posedge wr_clk); #1;
        while (n_acc < 2500 && budget < 60000) begin
          budget++;
          ba.wr_en   = ($urandom_range(0, 1) == 1);
          ba.wr_data = $urandom;
          if (ba.wr_en && !ba.fifo_full) begin
            for (int k = 0; k < 4; k++) qa.push_back(ba.wr_data[k*8 +: 8]);
            n_acc++;
          end
          if (ba.wr_data_count > 3'd4) viol++;
          @(posedge wr_clk); #1;
        end
        ba.wr_en = 1'b0;
        writer_done = 1'b1;
      end
      begin
        int budget = 0;
        @(posedge rd_clk); #1;
        while (!(writer_done && qa.size() == 0) && budget < 30000) begin
          budget++;
          ba.rd_en = ($urandom_range(0, 7) != 0);
          if (ba.rd_data_count > 5'd16) viol++;
          if (ba.fifo_empty == ba.rd_valid) viol++;
          @(posedge rd_clk); #1;
        end
        ba.rd_en = 1'b0;
      end
    join
    chk("t5_words_written", n_acc, 2500);
    chk("t5_drained", qa.size(), 0);
    chk("t5_invariants", viol, 0);

    // Reset both domains while half full
    @(posedge wr_clk); #1;
    wr_a(32'h0BADF00D, 1'b1);
    wr_a(32'hCAFE1234, 1'b1);
    repeat (10) @(posedge rd_clk); #1;
    chk("t6_half_full", ba.rd_data_count, 8);
    wr_rst_n = 1'b0; rd_rst_n = 1'b0;
    qa.delete();
    repeat (5) @(posedge rd_clk); #1;
    chk_reset_a("t6");
    wr_rst_n = 1'b1; rd_rst_n = 1'b1;
    repeat (3) @(posedge rd_clk);
    @(posedge wr_clk); #1;
    wr_a(32'hDEADBEEF, 1'b1);
    pop_a(4);
    chk("t6_empty_after", ba.fifo_empty, 1);

    repeat (4) @(posedge rd_clk); #1;
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/async_fifo_asym_v2.md
Name: async_fifo_asym_v2

Overview:
- Second-generation asynchronous FIFO with independent write and read clocks.
- Write and read widths may differ by any power-of-two ratio, in either direction: wide-to-narrow or narrow-to-wide.
- Adds selectable FWFT/standard read mode, programmable almost-full and almost-empty flags, a read-valid strobe, and overflow/underflow pulses.
- Drop-in buffer for width conversion between clock domains.

Parameters:
- WR_WIDTH, 32, write data width in bits.
- RD_WIDTH, 8, read data width in bits. max(WR,RD)/min(WR,RD) must be a power of two.
- UNIT_W, 8, storage unit width; must equal min(WR_WIDTH, RD_WIDTH).
- DEPTH, 16, storage depth in UNIT_W units; power of two; at least 2×max ratio.
- ADDR_W, 4, log2(DEPTH).
- WR_R, 4, WR_WIDTH/UNIT_W.
- RD_R, 1, RD_WIDTH/UNIT_W.
- WR_L2, 2, log2(WR_R).
- RD_L2, 0, log2(RD_R).
- FWFT, 1, read mode: 1 = first-word-fall-through; 0 = standard, registered read.
- SYNC_STG, 2, number of synchroniser flops per crossing; range 2..4.
- PFULL, 3, prog_full threshold, in write words.
- PEMPTY, 1, prog_empty threshold, in read words.

Ports:
- rd_clk  in  1  read clock.
- rd_rst_n  in  1  read-domain reset, asynchronous, active-low.
- wr_clk  in  1  write clock.
- wr_rst_n  in  1  write-domain reset, asynchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  WR_WIDTH  write data.
- fifo_full  out  1  fewer than WR_R free units.
- prog_full  out  1  wr_data_count >= PFULL.
- wr_overflow  out  1  one-cycle pulse: wr_en while full.
- wr_data_count  out  ADDR_W+1-WR_L2  occupancy in write words (conservative).
- rd_en  in  1  read request / pop.
- rd_data  out  RD_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- fifo_empty  out  1  fewer than RD_R units available.
- prog_empty  out  1  rd_data_count <= PEMPTY.
- rd_underflow  out  1  one-cycle pulse: rd_en while empty.
- rd_data_count  out  ADDR_W+1-RD_L2  occupancy in read words (conservative).

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are ADDR_W+1 bits wide, in units, with MSB wrap.
  - wr_ptr advances by WR_R per accepted write; rd_ptr advances by RD_R per accepted read.
  - Only the upper ADDR_W+1-WR_L2 bits (write side) and ADDR_W+1-RD_L2 bits (read side) are Gray-coded and crossed, each through SYNC_STG flops.
  - The synchronised value is converted Gray-to-binary and zero-filled in its low bits.
- Ordering:
  - Wide write: slice [UNIT_W-1:0] goes to the lowest address and is read first.
  - Narrow-to-wide: the first-written unit lands in rd_data[UNIT_W-1:0].
- Accept rules:
  - Write accepted iff wr_en && !fifo_full.
  - Read accepted iff rd_en && !fifo_empty.
  - Rejected requests do not move pointers or touch memory. They raise wr_overflow / rd_underflow for exactly one cycle of the requesting clock.
- Flags and counts:
  - wr_data_count = (wr_ptr - rd_ptr_sync) >> WR_L2.
  - rd_data_count = (wr_ptr_sync - rd_ptr) >> RD_L2.
  - fifo_full when wr_ptr - rd_ptr_sync > DEPTH - WR_R.
  - fifo_empty when wr_ptr_sync - rd_ptr < RD_R.
  - Flags are combinational from local pointer and sync registers, and update the same cycle as a local pointer change.
  - Full and empty are pessimistic only; they never falsely report space or data.
- Crossing latency:
  - A write becomes visible on the read side SYNC_STG+1 rd_clk edges after the write edge, worst case. The read-to-write direction is symmetric.
- FWFT=1:
  - rd_valid = !fifo_empty.
  - rd_data shows the head word whenever rd_valid is high.
  - An accepted read presents the next word on the following rd_clk edge: RAM read address = rd_ptr+RD_R while popping, else rd_ptr.
- FWFT=0:
  - rd_data is registered and updates one rd_clk after an accepted read.
  - rd_valid pulses high that same cycle.
  - rd_data holds its value otherwise.
- Reset:
  - Outputs during or after reset: fifo_empty=1, fifo_full=0, prog_empty=1, prog_full=0, counts=0, rd_valid=0, rd_data=0, overflow/underflow=0.
  - Each reset clears only its own domain's pointer, sync chain and outputs.
  - A flush requires both resets to overlap by at least SYNC_STG+1 cycles of the slower clock.
  - If one domain alone is reset mid-operation, stored data is lost; flags stay non-X and recover to a consistent state after both resets have cycled.
- Simultaneous events:
  - Read and write in the same instant are independent; no priority is needed.
  - A pop that frees space deasserts fifo_full only after crossing latency.
- Wrap:
  - Pointer MSB toggles every DEPTH units. Full/empty are correct across arbitrary wraps.

Test Plan:
- Defaults (32→8, DEPTH=16), FWFT=1: write 0x44332211 and 0x88776655 → after sync, reads return 0x11,0x22,…,0x88 in order; fifo_empty=1 after the 8th pop.
- Fill: 4 writes with no reads → fifo_full=1 after the 4th; prog_full=1 from the 3rd; a 5th wr_en yields a wr_overflow pulse and data is unchanged on readback.
- Widening 8→32, FWFT=0: write 0xA1,0xB2,0xC3,0xD4 → fifo_empty deasserts; one rd_en gives rd_data=0xD4C3B2A1 with rd_valid pulsing one cycle later.
- Underflow: rd_en on empty → rd_underflow for exactly 1 cycle; rd_ptr and rd_data unchanged.
- Wrap and ratio: wr_clk 100 MHz, rd_clk 37 MHz, random wr_en/rd_en, 10,000 words → scoreboard shows zero mismatches, no full/empty violation, and counts never exceed capacity.
- Reset mid-stream: assert both resets while half full, hold 5 slow cycles → all outputs return to reset values; a subsequent write/read round-trip is correct.
